// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------------------------------------------------------------------
// Shares one memory port between two masters: M0 (processor) and M1 (DMA,
// debug loader, ...). Each transaction is captured into bus registers when it
// is granted. The registered address, data and strobe are held on the memory
// side until the memory answers with iMemRdy. The owner then gets a one-cycle
// Done pulse, and for reads also the registered read data. A watchdog ends a
// transaction with an error pulse if the memory never answers.
//
// Handshake: a master raises Read and/or Write (a level) with a stable
// address/data and keeps it up until it sees its Done pulse. The memory side
// sees a strobe (oMemRead/oMemWrite) for the whole BUSY phase. The access
// completes on the first rising edge where the strobe is high and iMemRdy = 1.
// Done follows one cycle later. iMemRdy has no effect while no strobe is high.
//
// Parameters : ADDR_W, DATA_W, TIMEOUT (0 disables the watchdog)
// Ports      : iClk, nRst (async, active low)
//              iMxRead/iMxWrite/iMxAddr/iMxData   master x request
//              oMxData/oMxDone/oMxErr             master x response
//              oMemAddr/oMemData/oMemRead/oMemWrite, iMemData/iMemRdy  memory
//              oGrant    one-hot owner (bit0 = M0, bit1 = M1), 00 when idle
//              oDbgState FSM state (0 idle, 1 busy, 2 done)
// Option     : `define MEM_ARB_ROUND_ROBIN_EN gives round-robin tie breaking.
//              When it is not defined, M0 always wins ties.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iM0Read,
  input  logic              iM0Write,
  input  logic [ADDR_W-1:0] iM0Addr,
  input  logic [DATA_W-1:0] iM0Data,
  output logic [DATA_W-1:0] oM0Data,
  output logic              oM0Done,
  output logic              oM0Err,
  input  logic              iM1Read,
  input  logic              iM1Write,
  input  logic [ADDR_W-1:0] iM1Addr,
  input  logic [DATA_W-1:0] iM1Data,
  output logic [DATA_W-1:0] oM1Data,
  output logic              oM1Done,
  output logic              oM1Err,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemRdy,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [1:0]        oGrant,
  output logic [1:0]        oDbgState
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold TIMEOUT-1. Keep at least one bit so the
  // disabled watchdog (TIMEOUT = 0) still elaborates.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;      // 0 = M0, 1 = M1
  logic              wr_q, wr_d;            // 1 = write, 0 = read
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic req0, req1, grant_m1, prio_m1;

  assign req0 = iM0Read | iM0Write;
  assign req1 = iM1Read | iM1Write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // After a completed transaction the pointer moves to the master that was
  // not served. This way a master that keeps requesting cannot win two ties
  // in a row.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_DONE) rr_ptr_d = ~owner_q;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign prio_m1 = rr_ptr_q;
`else
  assign prio_m1 = 1'b0;
`endif

  // M1 wins if it is the only requester, or if there is a tie and it holds
  // priority.
  assign grant_m1 = req1 & (~req0 | prio_m1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (req0 | req1) begin
          owner_d = grant_m1;
          // Read and Write both high is treated as a write.
          wr_d    = grant_m1 ? iM1Write : iM0Write;
          addr_d  = grant_m1 ? iM1Addr  : iM0Addr;
          wdata_d = grant_m1 ? iM1Data  : iM0Data;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (iMemRdy) begin
          if (!wr_q) begin
            if (owner_q) m1_rdata_d = iMemData;
            else         m0_rdata_d = iMemData;
          end
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  logic busy, done;
  assign busy = (state_q == ST_BUSY);
  assign done = (state_q == ST_DONE);

  assign oMemAddr  = addr_q;
  assign oMemData  = wdata_q;
  assign oMemRead  = busy & ~wr_q;
  assign oMemWrite = busy & wr_q;
  assign oGrant    = (busy | done) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign oM0Done   = done & ~owner_q;
  assign oM1Done   = done & owner_q;
  assign oM0Err    = done & ~owner_q & err_q;
  assign oM1Err    = done & owner_q & err_q;
  assign oM0Data   = m0_rdata_q;
  assign oM1Data   = m1_rdata_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (TIMEOUT = 8).
// The reference is a transaction-level model. It tracks whether a
// transaction is on the bus, how many bus cycles it has used, and whether it
// is in its completion cycle. Every negedge compares the DUT against it. A
// queue of expected completions is checked on every Done pulse.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          iClk, nRst;
  logic          iM0Read, iM0Write, iM1Read, iM1Write;
  logic [AW-1:0] iM0Addr, iM1Addr;
  logic [DW-1:0] iM0Data, iM1Data;
  logic [DW-1:0] oM0Data, oM1Data;
  logic          oM0Done, oM0Err, oM1Done, oM1Err;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemData, iMemData;
  logic          iMemRdy, oMemRead, oMemWrite;
  logic [1:0]    oGrant, oDbgState;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .iClk(iClk), .nRst(nRst),
    .iM0Read(iM0Read), .iM0Write(iM0Write), .iM0Addr(iM0Addr), .iM0Data(iM0Data),
    .oM0Data(oM0Data), .oM0Done(oM0Done), .oM0Err(oM0Err),
    .iM1Read(iM1Read), .iM1Write(iM1Write), .iM1Addr(iM1Addr), .iM1Data(iM1Data),
    .oM1Data(oM1Data), .oM1Done(oM1Done), .oM1Err(oM1Err),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemData(iMemData), .iMemRdy(iMemRdy),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oGrant(oGrant), .oDbgState(oDbgState)
  );

  // ---------------- clock / reset ----------------
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_busy, m_done, m_owner, m_write, m_err, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata0, m_rdata1;
  int            m_used;   // bus cycles already spent by the current transaction
  logic [DW+1:0] exp_q[$]; // {master, err, data seen by that master}

  logic tb_req0, tb_req1, tb_prio_m1, tb_win_m1;
  assign tb_req0 = iM0Read | iM0Write;
  assign tb_req1 = iM1Read | iM1Write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tb_prio_m1 = m_ptr;
`else
  assign tb_prio_m1 = 1'b0;
`endif
  assign tb_win_m1 = tb_req1 && (!tb_req0 || tb_prio_m1);

  always @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      m_busy <= 0; m_done <= 0; m_owner <= 0; m_write <= 0; m_err <= 0; m_ptr <= 0;
      m_addr <= 0; m_wdata <= 0; m_rdata0 <= 0; m_rdata1 <= 0; m_used <= 0;
      exp_q.delete();
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (iMemRdy) begin
        m_busy <= 0; m_done <= 1; m_err <= 0; m_ptr <= !m_owner;
        if (!m_write) begin
          if (m_owner) m_rdata1 <= iMemData; else m_rdata0 <= iMemData;
          exp_q.push_back({m_owner, 1'b0, iMemData});
        end else begin
          exp_q.push_back({m_owner, 1'b0, m_owner ? m_rdata1 : m_rdata0});
        end
      end else if (m_used + 1 == TO) begin
        m_busy <= 0; m_done <= 1; m_err <= 1; m_ptr <= !m_owner;
        exp_q.push_back({m_owner, 1'b1, m_owner ? m_rdata1 : m_rdata0});
      end else begin
        m_used <= m_used + 1;
      end
    end else if (tb_req0 || tb_req1) begin
      m_busy  <= 1;
      m_used  <= 0;
      m_owner <= tb_win_m1;
      m_write <= tb_win_m1 ? iM1Write : iM0Write;
      m_addr  <= tb_win_m1 ? iM1Addr : iM0Addr;
      m_wdata <= tb_win_m1 ? iM1Data : iM0Data;
    end
  end

  // ---------------- compare process / scoreboard ----------------
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge iClk);
      if (nRst) begin
        chk("grant", 64'(oGrant), (m_busy || m_done) ? (m_owner ? 64'h2 : 64'h1) : 64'h0);
        chk("mem_read", 64'(oMemRead), 64'(m_busy && !m_write));
        chk("mem_write", 64'(oMemWrite), 64'(m_busy && m_write));
        chk("m0_done", 64'(oM0Done), 64'(m_done && !m_owner));
        chk("m1_done", 64'(oM1Done), 64'(m_done && m_owner));
        chk("m0_err", 64'(oM0Err), 64'(m_done && !m_owner && m_err));
        chk("m1_err", 64'(oM1Err), 64'(m_done && m_owner && m_err));
        chk("m0_data", 64'(oM0Data), 64'(m_rdata0));
        chk("m1_data", 64'(oM1Data), 64'(m_rdata1));
        if (m_busy) begin
          chk("mem_addr", 64'(oMemAddr), 64'(m_addr));
          chk("mem_wdata", 64'(oMemData), 64'(m_wdata));
        end
        if (oM0Done || oM1Done) begin
          chk("sb_nonempty", 64'(exp_q.size() != 0), 64'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_txn", 64'({oM1Done, oM0Err | oM1Err, oM1Done ? oM1Data : oM0Data}), 64'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nclk();
    @(negedge iClk);
  endtask

  task automatic clear_inputs();
    iM0Read = 0; iM0Write = 0; iM0Addr = 0; iM0Data = 0;
    iM1Read = 0; iM1Write = 0; iM1Addr = 0; iM1Data = 0;
    iMemRdy = 0; iMemData = 0;
  endtask

  task automatic do_reset();
    nRst = 0;
    clear_inputs();
    nclk(); nclk();
    nRst = 1;
    nclk();
  endtask

  task automatic wait_done(input int m, input int max_cyc, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      nclk();
      if ((m == 0 && oM0Done) || (m == 1 && oM1Done)) seen = 1;
    end
  endtask

  task automatic rand_master(input logic done_i, inout logic rd, inout logic wr,
                             inout logic [AW-1:0] addr, inout logic [DW-1:0] data);
    int op;
    if (rd || wr) begin
      if (done_i) begin
        if ($urandom_range(0, 3) == 0) begin
          addr = $urandom; data = $urandom;  // immediately request again
        end else begin
          rd = 0; wr = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        addr = $urandom;  // wiggle address; ignored once owned
      end
    end else if ($urandom_range(0, 3) == 0) begin
      op = $urandom_range(1, 3);
      rd = op[0]; wr = op[1];
      addr = $urandom; data = $urandom;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int cnt, nd, n;
    int order[4];

    nRst = 0;
    clear_inputs();
    nclk(); nclk();
    chk("rst_grant", 64'(oGrant), 64'h0);
    chk("rst_read", 64'(oMemRead), 64'h0);
    chk("rst_write", 64'(oMemWrite), 64'h0);
    chk("rst_done", 64'({oM0Done, oM1Done, oM0Err, oM1Err}), 64'h0);
    chk("rst_addr", 64'(oMemAddr), 64'h0);
    chk("rst_data", 64'({oM0Data, oM1Data}), 64'h0);
    nRst = 1;
    nclk();

    // M0 read of 0x14, memory answers in the first bus cycle with 60.
    iM0Read = 1; iM0Addr = 32'h14; iMemRdy = 1; iMemData = 32'd60;
    nclk();
    chk("t1_read", 64'(oMemRead), 64'h1);
    chk("t1_grant_busy", 64'(oGrant), 64'h1);
    chk("t1_addr", 64'(oMemAddr), 64'h14);
    nclk();
    chk("t1_done", 64'(oM0Done), 64'h1);
    chk("t1_data", 64'(oM0Data), 64'd60);
    chk("t1_read_low", 64'(oMemRead), 64'h0);
    chk("t1_grant_done", 64'(oGrant), 64'h1);
    iM0Read = 0; iMemRdy = 0;
    nclk();
    chk("t1_grant_idle", 64'(oGrant), 64'h0);

    // M1 write 0xDEADBEEF to 0x16, memory answers in the 5th bus cycle.
    iM1Write = 1; iM1Addr = 32'h16; iM1Data = 32'hDEADBEEF;
    for (int i = 1; i <= 5; i++) begin
      nclk();
      chk("t2_write", 64'(oMemWrite), 64'h1);
      chk("t2_addr", 64'(oMemAddr), 64'h16);
      chk("t2_wdata", 64'(oMemData), 64'hDEADBEEF);
      if (i == 5) iMemRdy = 1;
    end
    nclk();
    chk("t2_done", 64'(oM1Done), 64'h1);
    chk("t2_m1data", 64'(oM1Data), 64'h0);
    iM1Write = 0; iMemRdy = 0;
    nclk();
    chk("t2_done_once", 64'(oM1Done), 64'h0);

    // Both masters request continuously.
    do_reset();
    iM0Read = 1; iM0Addr = 32'h100; iM1Read = 1; iM1Addr = 32'h200;
    iMemRdy = 1; iMemData = 32'h55;
    n = 0;
    for (int i = 0; i < 4; i++) order[i] = 9;
    for (int c = 0; c < 40 && n < 4; c++) begin
      nclk();
      if (oM0Done) begin order[n] = 0; n++; end
      else if (oM1Done) begin order[n] = 1; n++; end
    end
    iM0Read = 0; iM1Read = 0; iMemRdy = 0;
    chk("t3_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("t3_order", 64'(order[i]), 64'(i % 2));
`else
      chk("t3_order", 64'(order[i]), 64'h0);
`endif
    end
    nclk();

    // Watchdog: M0 read never answered; M1 write waits behind it.
    iM0Read = 1; iM0Addr = 32'h40;
    cnt = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      nclk();
      if (oMemRead) cnt++;
      if (cnt == 1) begin iM1Write = 1; iM1Addr = 32'h44; iM1Data = 32'h1234; end
      if (oM0Done) seen = 1;
    end
    chk("t4_done", 64'(seen), 64'h1);
    chk("t4_busy_cycles", 64'(cnt), 64'd8);
    chk("t4_err", 64'(oM0Err), 64'h1);
    iM0Read = 0; iMemRdy = 1;
    wait_done(1, 20, seen);
    chk("t4_m1_done", 64'(seen), 64'h1);
    chk("t4_m1_err", 64'(oM1Err), 64'h0);
    chk("t4_m1_grant", 64'(oGrant), 64'h2);
    iM1Write = 0; iMemRdy = 0;
    nclk();

    // Reset in the middle of a bus cycle.
    iM0Read = 1; iM0Addr = 32'h50; iMemData = 32'h99;
    nclk(); nclk();
    chk("t5_busy", 64'(oMemRead), 64'h1);
    nRst = 0;
    #1;
    chk("t5_read", 64'(oMemRead), 64'h0);
    chk("t5_grant", 64'(oGrant), 64'h0);
    chk("t5_addr", 64'(oMemAddr), 64'h0);
    chk("t5_m0data", 64'(oM0Data), 64'h0);
    iM0Read = 0;
    nclk();
    nRst = 1;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      nclk();
      if (oM0Done || oM1Done) nd++;
    end
    chk("t5_no_done", 64'(nd), 64'h0);
    iM0Read = 1; iM0Addr = 32'h58; iMemRdy = 1; iMemData = 32'hCAFE0001;
    wait_done(0, 10, seen);
    chk("t5_new_done", 64'(seen), 64'h1);
    chk("t5_new_data", 64'(oM0Data), 64'hCAFE0001);
    iM0Read = 0; iMemRdy = 0;
    nclk();

    // Address changes while owned are ignored.
    iM0Read = 1; iM0Addr = 32'h20;
    for (int i = 1; i <= 4; i++) begin
      nclk();
      chk("t6_addr", 64'(oMemAddr), 64'h20);
      if (i == 1) iM0Addr = 32'h30;
      if (i == 4) begin iMemRdy = 1; iMemData = 32'd7; end
    end
    nclk();
    chk("t6_done", 64'(oM0Done), 64'h1);
    chk("t6_data", 64'(oM0Data), 64'd7);
    iM0Read = 0; iMemRdy = 0;
    nclk();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      nclk();
      rand_master(oM0Done, iM0Read, iM0Write, iM0Addr, iM0Data);
      rand_master(oM1Done, iM1Read, iM1Write, iM1Addr, iM1Data);
      iMemRdy  = ($urandom_range(0, 2) == 0);
      iMemData = $urandom;
    end
    iM0Read = 0; iM0Write = 0; iM1Read = 0; iM1Write = 0; iMemRdy = 1;
    repeat (20) nclk();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single Processor memory port (addr/data/read/write/ready) between the Processor (M0) and a secondary master such as DMA or debug loader (M1).
- Sits between the masters and the memory/peripheral bus.
- Serialises transactions, holds address/data/strobes stable until memory signals ready, and returns read data and a one-cycle done pulse to the granted master.
- Adds a bus-timeout watchdog.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles to wait for iMemRdy before aborting; 0 disables the watchdog.

Ports:
- iClk  in  1  system clock, rising edge
- nRst  in  1  asynchronous active-low reset
- iM0Read  in  1  M0 read request, level, held until oM0Done
- iM0Write  in  1  M0 write request, level, held until oM0Done
- iM0Addr  in  ADDR_W  M0 address
- iM0Data  in  DATA_W  M0 write data
- oM0Data  out  DATA_W  M0 read data, registered
- oM0Done  out  1  M0 transaction complete, 1-cycle pulse
- oM0Err  out  1  M0 timeout abort, 1-cycle pulse, coincident with oM0Done
- iM1Read, iM1Write, iM1Addr, iM1Data, oM1Data, oM1Done, oM1Err: same as M0, for master 1
- oMemAddr  out  ADDR_W  to memory
- oMemData  out  DATA_W  write data to memory
- iMemData  in  DATA_W  read data from memory
- iMemRdy  in  1  memory ready / transaction accept
- oMemRead  out  1  read strobe
- oMemWrite  out  1  write strobe
- oGrant  out  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 when idle

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state IDLE; all outputs 0; wait counter 0; priority pointer = M0. An in-flight memory access is abandoned; no Done is issued.
- States:
  - IDLE:
    - Sample requests (req = Read | Write).
    - If exactly one master requests, grant it.
    - If both request, grant per the priority rule.
    - On grant, register addr, data and op into the bus registers; go to BUSY next edge.
  - BUSY:
    - oMemAddr, oMemData, oMemRead/oMemWrite and oGrant are driven from registers, stable the whole state.
    - Wait counter increments each cycle.
    - iMemRdy = 1 sampled: latch iMemData into the owner's oMxData (reads only; writes leave oMxData unchanged); go to DONE.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1: go to DONE with error flag set.
  - DONE (exactly 1 cycle):
    - Strobes low; oGrant still shows the owner.
    - Owner's oMxDone = 1; oMxErr = error flag; counter cleared.
    - Requests are not sampled in DONE; the master must drop its request in this cycle or it will be re-granted as a new transaction.
    - Next state IDLE.
- Latency: request seen at edge N -> strobe high from N+1 -> iMemRdy at edge N+k (k >= 1) -> Done high in cycle after N+k.
  - Minimum: request to Done = 3 cycles.
  - Back-to-back transactions from the same master: one IDLE cycle between transactions.
- Read and Write both high from one master: treated as write; read data not updated.
- Requests that change while that master owns the bus are ignored; the registered values are used.
- Requests from the non-owner are held pending. They are never dropped and are granted at the next IDLE evaluation.
- iMemRdy outside BUSY is ignored.
- Priority rule without the optional feature: fixed, M0 wins ties.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A priority pointer toggles to the other master after each completed transaction (Done, including timeout).
  - Ties are granted to the pointer's master.
  - No master waits more than one transaction while the other is continuously requesting.
- Undefined:
  - Fixed priority, M0 always wins ties.
  - The pointer register is not instantiated.

Test Plan:
- M0 read addr 0x14, memory returns 32'd60 with iMemRdy on the first BUSY cycle -> oMemRead high 1 cycle, oM0Data = 60, oM0Done pulses 3 cycles after request, oGrant = 01 then 00.
- M1 write addr 0x16, data 32'hDEADBEEF, iMemRdy delayed 4 cycles -> oMemWrite/addr/data stable all 5 BUSY cycles, oM1Done once, oM1Data unchanged.
- M0 and M1 request simultaneously, both continuous:
  - Fixed priority: M0 served for 3 consecutive transactions.
  - With MEM_ARB_ROUND_ROBIN_EN: grant order M0, M1, M0, M1.
- TIMEOUT = 8, iMemRdy held 0 -> strobe drops after 8 BUSY cycles, oM0Done = oM0Err = 1 for one cycle, bus returns to IDLE and then serves a pending M1 request normally.
- nRst pulsed low during BUSY -> all outputs 0 immediately (asynchronous); after release no Done is issued for the aborted transaction; a new M0 request completes normally.
- M0 changes iM0Addr from 0x20 to 0x30 mid-BUSY -> oMemAddr remains 0x20 until DONE.
